// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
// Derived widths are computed here so every block agrees on the address split.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        UPDATE,
        FLUSH
    } icache_state_t;

    function automatic int unsigned offset_width(input int unsigned words_per_line);
        return $clog2(words_per_line * 4);
    endfunction

    function automatic int unsigned index_width(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_width(input int unsigned num_sets,
                                              input int unsigned words_per_line);
        return 32 - offset_width(words_per_line) - index_width(num_sets);
    endfunction

    function automatic int unsigned beat_width(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // A direct-mapped cache still carries a 1-bit way number so ports stay legal.
    function automatic int unsigned way_width(input int unsigned num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int unsigned num_sets,
                                        input int unsigned num_ways,
                                        input int unsigned words_per_line,
                                        input int unsigned counter_width);
        return is_pow2(num_sets) && (num_sets >= 2) &&
               is_pow2(num_ways) && (num_ways >= 1) && (num_ways <= 8) &&
               is_pow2(words_per_line) && (words_per_line >= 2) && (words_per_line <= 16) &&
               (counter_width >= 1) &&
               (offset_width(words_per_line) + index_width(num_sets) < 32);
    endfunction

endpackage

// File: rtl/icache_rr_replacement.sv
// Per-set round-robin victim pointers; an invalid way always wins over the pointer.
module icache_rr_replacement
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS = 64,
    parameter int unsigned NUM_WAYS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [index_width(NUM_SETS)-1:0]     set_index,
    input  logic [NUM_WAYS-1:0]                  valid_vec,
    input  logic                                 advance,
    input  logic                                 clear_all,
    output logic [way_width(NUM_WAYS)-1:0]       victim_way,
    output logic                                 victim_invalid
);

    localparam int unsigned WAY_W = way_width(NUM_WAYS);

    logic [WAY_W-1:0] rr_ptr_q [NUM_SETS];
    logic [WAY_W-1:0] first_invalid;

    // Scan downwards so the lowest-numbered invalid way is the last one written.
    always_comb begin
        first_invalid  = '0;
        victim_invalid = 1'b0;
        for (int unsigned w = NUM_WAYS; w > 0; w--) begin
            if (!valid_vec[w-1]) begin
                first_invalid  = WAY_W'(w - 1);
                victim_invalid = 1'b1;
            end
        end
        victim_way = victim_invalid ? first_invalid : rr_ptr_q[set_index];
    end

    if (NUM_WAYS == 1) begin : g_direct_mapped
        always_comb begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                rr_ptr_q[s] = '0;
            end
        end
    end else begin : g_round_robin
        // NUM_WAYS is a power of two, so the natural WAY_W-bit overflow is the wrap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) begin
                    rr_ptr_q[s] <= '0;
                end
            end else if (clear_all) begin
                for (int unsigned s = 0; s < NUM_SETS; s++) begin
                    rr_ptr_q[s] <= '0;
                end
            end else if (advance) begin
                rr_ptr_q[set_index] <= rr_ptr_q[set_index] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_cache_set_assoc.sv
// N-way set-associative read-only instruction cache with line refill,
// fence.i-style invalidation and hit/miss performance counters.
module instruction_cache_set_assoc
    import icache_pkg::*;
#(
    parameter int unsigned NUM_SETS       = 64,
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned COUNTER_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              program_counter_address,
    output logic [31:0]              instruction,
    output logic                     stall_cpu,
    input  logic                     invalidate_all,
    output logic [31:0]              instruction_memory_address,
    output logic                     instruction_memory_request,
    input  logic [31:0]              instruction_memory_read_data,
    input  logic                     instruction_memory_ready,
    output logic [COUNTER_WIDTH-1:0] hit_count,
    output logic [COUNTER_WIDTH-1:0] miss_count
);

    localparam int unsigned OFF_W  = offset_width(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = index_width(NUM_SETS);
    localparam int unsigned TAG_W  = tag_width(NUM_SETS, WORDS_PER_LINE);
    localparam int unsigned BEAT_W = beat_width(WORDS_PER_LINE);
    localparam int unsigned WAY_W  = way_width(NUM_WAYS);
    localparam logic [31:0] LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);

    if (!params_legal(NUM_SETS, NUM_WAYS, WORDS_PER_LINE, COUNTER_WIDTH)) begin : g_param_check
        $error("instruction_cache_set_assoc: illegal NUM_SETS/NUM_WAYS/WORDS_PER_LINE/COUNTER_WIDTH");
    end

    icache_state_t     state_q;
    logic [31:0]       miss_addr_q;
    logic [BEAT_W-1:0] beat_q;
    logic              flush_pending_q;
    logic [NUM_SETS-1:0] valid_q [NUM_WAYS];

    logic [TAG_W-1:0]  tag_mem  [NUM_WAYS][NUM_SETS];
    logic [31:0]       data_mem [NUM_WAYS][NUM_SETS][WORDS_PER_LINE];
    logic [31:0]       refill_buf [WORDS_PER_LINE];

    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  pc_index;
    logic [BEAT_W-1:0] pc_word;
    logic              pc_unused_bits;
    logic [TAG_W-1:0]  miss_tag;
    logic [IDX_W-1:0]  miss_index;

    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [31:0]         hit_word;
    logic [NUM_WAYS-1:0] miss_valid_vec;
    logic [WAY_W-1:0]    victim_way;
    logic                victim_invalid;
    logic                flush_now;
    logic                install;

    assign pc_tag         = program_counter_address[31 -: TAG_W];
    assign pc_index       = program_counter_address[OFF_W +: IDX_W];
    assign pc_word        = program_counter_address[2 +: BEAT_W];
    assign pc_unused_bits = ^program_counter_address[1:0];
    assign miss_tag       = miss_addr_q[31 -: TAG_W];
    assign miss_index     = miss_addr_q[OFF_W +: IDX_W];

    always_comb begin
        hit_vec        = '0;
        hit_way        = '0;
        miss_valid_vec = '0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w]        = valid_q[w][pc_index] && (tag_mem[w][pc_index] == pc_tag);
            miss_valid_vec[w] = valid_q[w][miss_index];
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
        end
        hit      = |hit_vec;
        hit_word = data_mem[hit_way][pc_index][pc_word];
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == IDLE) begin
            assert ($onehot0(hit_vec)) else $error("instruction cache multi-way hit");
        end
    end

    // A flush request seen during UPDATE itself still suppresses the install.
    assign flush_now = flush_pending_q || invalidate_all;
    assign install   = (state_q == UPDATE) && !flush_now;

    icache_rr_replacement #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_rr_replacement (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_index      (miss_index),
        .valid_vec      (miss_valid_vec),
        .advance        (install && !victim_invalid),
        .clear_all      ((state_q == FLUSH) || ((state_q == UPDATE) && flush_now)),
        .victim_way     (victim_way),
        .victim_invalid (victim_invalid)
    );

    always_comb begin
        stall_cpu                  = 1'b0;
        instruction                = '0;
        instruction_memory_request = 1'b0;
        instruction_memory_address = '0;
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    stall_cpu   = invalidate_all || !hit;
                    instruction = stall_cpu ? '0 : hit_word;
                end
                REFILL: begin
                    stall_cpu                  = 1'b1;
                    instruction_memory_request = 1'b1;
                    instruction_memory_address = miss_addr_q + {{(30 - BEAT_W){1'b0}}, beat_q, 2'b00};
                end
                UPDATE, FLUSH: stall_cpu = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            miss_addr_q     <= '0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            hit_count       <= '0;
            miss_count      <= '0;
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (invalidate_all) begin
                        state_q <= FLUSH;
                    end else if (hit) begin
                        hit_count <= hit_count + 1'b1;
                    end else begin
                        miss_addr_q <= program_counter_address & ~LINE_MASK;
                        beat_q      <= '0;
                        miss_count  <= miss_count + 1'b1;
                        state_q     <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate_all) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (instruction_memory_ready) begin
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
                            state_q <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    if (flush_now) begin
                        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                            valid_q[w] <= '0;
                        end
                    end else begin
                        valid_q[victim_way][miss_index] <= 1'b1;
                    end
                    flush_pending_q <= 1'b0;
                    state_q         <= IDLE;
                end
                FLUSH: begin
                    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                        valid_q[w] <= '0;
                    end
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == REFILL && instruction_memory_ready) begin
            refill_buf[beat_q] <= instruction_memory_read_data;
        end
        if (install) begin
            tag_mem[victim_way][miss_index] <= miss_tag;
            for (int unsigned k = 0; k < WORDS_PER_LINE; k++) begin
                data_mem[victim_way][miss_index][k] <= refill_buf[k];
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache_set_assoc.sv
// Directed bench: a refill-beat scoreboard plus stall/instruction/counter checks.
module tb_instruction_cache_set_assoc;

    logic        clk;
    logic        rst_n;
    logic [31:0] program_counter_address;
    logic [31:0] instruction;
    logic        stall_cpu;
    logic        invalidate_all;
    logic [31:0] instruction_memory_address;
    logic        instruction_memory_request;
    logic [31:0] instruction_memory_read_data;
    logic        instruction_memory_ready;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] beat_sb [$];

    instruction_cache_set_assoc #(
        .NUM_SETS       (64),
        .NUM_WAYS       (2),
        .WORDS_PER_LINE (4),
        .COUNTER_WIDTH  (32)
    ) dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .program_counter_address      (program_counter_address),
        .instruction                  (instruction),
        .stall_cpu                    (stall_cpu),
        .invalidate_all               (invalidate_all),
        .instruction_memory_address   (instruction_memory_address),
        .instruction_memory_request   (instruction_memory_request),
        .instruction_memory_read_data (instruction_memory_read_data),
        .instruction_memory_ready     (instruction_memory_ready),
        .hit_count                    (hit_count),
        .miss_count                   (miss_count)
    );

    assign instruction_memory_read_data = instruction_memory_address ^ 32'hA5A5A5A5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Every accepted refill beat must match the next address queued by the stimulus.
    always @(negedge clk) begin
        if (rst_n && instruction_memory_request && instruction_memory_ready) begin
            checks++;
            assert (beat_sb.size() != 0) else begin
                errors++;
                $error("FAIL beat_unexpected observed=%h expected=none", instruction_memory_address);
            end
            if (beat_sb.size() != 0) check("beat_addr", instruction_memory_address, beat_sb.pop_front());
        end
    end

    task automatic expect_line(input logic [31:0] addr);
        for (int b = 0; b < 4; b++) beat_sb.push_back((addr & ~32'hF) + 32'(b * 4));
        exp_misses++;
    endtask

    task automatic drive_pc(input logic [31:0] addr);
        @(posedge clk);
        #1;
        program_counter_address = addr;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_count"}, hit_count, exp_hits);
        check({tag, "_miss_count"}, miss_count, exp_misses);
    endtask

    // Called at a sample point; counts stalled samples up to the first hit.
    task automatic await_hit(input logic [31:0] addr, input int exp_stalls, input string tag);
        int stalls = 0;
        while (stall_cpu === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        check({tag, "_stalls"}, stalls, exp_stalls);
        check({tag, "_instr"}, instruction, addr ^ 32'hA5A5A5A5);
        exp_hits++;
    endtask

    task automatic fetch(input logic [31:0] addr, input bit miss, input string tag);
        drive_pc(addr);
        @(negedge clk);
        check_counters(tag);
        if (miss) expect_line(addr);
        await_hit(addr, miss ? 6 : 0, tag);
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1;
        invalidate_all = 1'b1;
        @(negedge clk);
        check("flush_pulse_stall", stall_cpu, 1'b1);
        check("flush_pulse_instr", instruction, 32'h0);
        @(posedge clk);
        #1;
        invalidate_all = 1'b0;
        @(negedge clk);
        check("flush_state_stall", stall_cpu, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        program_counter_address = 32'h100;
        invalidate_all = 1'b0;
        instruction_memory_ready = 1'b1;
        #1;
        check("rst_stall", stall_cpu, 1'b0);
        check("rst_request", instruction_memory_request, 1'b0);
        check("rst_address", instruction_memory_address, 32'h0);
        check("rst_instr", instruction, 32'h0);
        check_counters("rst");

        // Cold miss on 0x100 starts in the very cycle reset is released.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("cold_detect_request", instruction_memory_request, 1'b0);
        expect_line(32'h100);
        await_hit(32'h100, 6, "cold");

        // Same set: third distinct line evicts way 0 (line 0x000).
        fetch(32'h000, 1, "conf_a");
        fetch(32'h400, 1, "conf_b");
        fetch(32'h800, 1, "conf_c");
        fetch(32'h400, 0, "conf_b_hit");
        fetch(32'h000, 1, "conf_a_evicted");

        // Invalidate in IDLE drops every line without touching the counters.
        fetch(32'h200, 1, "pre_flush_200");
        fetch(32'h100, 0, "pre_flush_100");
        do_flush();
        fetch(32'h100, 1, "post_flush_100");
        fetch(32'h200, 1, "post_flush_200");

        // Ready held low on beat 2 while the PC wanders off to 0x500.
        do_flush();
        drive_pc(32'h100);
        expect_line(32'h100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        instruction_memory_ready = 1'b0;
        program_counter_address = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_hold_address", instruction_memory_address, 32'h108);
            check("ready_hold_request", instruction_memory_request, 1'b1);
            @(posedge clk); #1;
        end
        instruction_memory_ready = 1'b1;
        expect_line(32'h500);
        @(negedge clk);
        await_hit(32'h500, 9, "pc_moved");
        fetch(32'h100, 0, "installed_100");

        // Invalidate during REFILL beat 1: beats finish, line is dropped, refetched.
        drive_pc(32'h300);
        expect_line(32'h300);
        expect_line(32'h300);
        @(posedge clk); #1;
        @(posedge clk); #1;
        invalidate_all = 1'b1;
        @(posedge clk); #1;
        invalidate_all = 1'b0;
        @(negedge clk);
        await_hit(32'h300, 9, "refill_flush");

        // Reset during REFILL beat 2.
        drive_pc(32'h700);
        beat_sb.push_back(32'h700);
        beat_sb.push_back(32'h704);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        program_counter_address = 32'h300;
        exp_hits = 0;
        exp_misses = 0;
        #1;
        check("midrst_stall", stall_cpu, 1'b0);
        check("midrst_request", instruction_memory_request, 1'b0);
        check("midrst_address", instruction_memory_address, 32'h0);
        check_counters("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_counters("post_rst");
        expect_line(32'h300);
        await_hit(32'h300, 6, "post_rst_300");

        @(negedge clk);
        check("beats_outstanding", beat_sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
